vr_wheel_gen: RTL and testbench

Synthesizable crank-wheel pattern generator that drives the `vr_in` input of `hwag`, acting as the transmitter end of the tooth signal `hwag` decodes. It produces a TOOTH_NUM−MISS_NUM tooth wheel, 60−2 by default, with a programmable per-tooth period in `clk` cycles. Period updates are applied at tooth boundaries, so acceleration can be emulated. It is used on-chip for self-test and in benches, and replaces the free-running square wave generator.

---
 rtl/vr_wheel_gen.sv | 116 +++++++++++
 tb/tb_vr_wheel_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vr_wheel_gen.sv
// rtl/vr_wheel_gen.sv - crank-wheel tooth pattern generator for the hwag vr_in input
// Generates a TOOTH_NUM-MISS_NUM wheel with a per-tooth period that is picked up at tooth boundaries.
module vr_wheel_gen #(
  parameter int TOOTH_NUM  = 60,
  parameter int MISS_NUM   = 2,
  parameter int PERIOD_W   = 24,
  parameter int PERIOD_RST = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [PERIOD_W-1:0]          period_in,
  input  logic                         period_we,
  output logic                         vr_out,
  output logic [$clog2(TOOTH_NUM)-1:0] tooth_cnt,
  output logic                         tooth_pulse,
  output logic                         rev_pulse,
  output logic [PERIOD_W-1:0]          period_act
);

  localparam int TW = $clog2(TOOTH_NUM);
  localparam logic [TW-1:0]       LAST_TOOTH = TW'(TOOTH_NUM - 1);
  localparam logic [TW-1:0]       REAL_NUM   = TW'(TOOTH_NUM - MISS_NUM);
  localparam logic [PERIOD_W-1:0] P_RST      = PERIOD_W'(PERIOD_RST);
  localparam logic [PERIOD_W-1:0] P_MIN      = PERIOD_W'(2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [PERIOD_W-1:0] shadow;
  logic [PERIOD_W-1:0] phase;

  logic [PERIOD_W-1:0] phase_inc;
  logic [PERIOD_W-1:0] half;
  logic                at_end;
  logic [TW-1:0]       next_tooth;
  logic                cur_real;
  logic                next_real;

  assign phase_inc  = phase + PERIOD_W'(1);
  assign half       = period_act >> 1;
  assign at_end     = (phase == period_act - PERIOD_W'(1));
  assign next_tooth = (tooth_cnt == LAST_TOOTH) ? '0 : tooth_cnt + TW'(1);
  assign cur_real   = (tooth_cnt < REAL_NUM);
  assign next_real  = (next_tooth < REAL_NUM);

  // Clamping to 2 keeps the high half of every real tooth at least one cycle long.
  always_ff @(posedge clk) begin
    if (rst)
      shadow <= P_RST;
    else if (period_we)
      shadow <= (period_in < P_MIN) ? P_MIN : period_in;
  end

  // Outputs are computed for the phase/tooth being entered, so they are all registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= '0;
      tooth_cnt   <= '0;
      period_act  <= P_RST;
      vr_out      <= 1'b0;
      tooth_pulse <= 1'b0;
      rev_pulse   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          phase     <= '0;
          tooth_cnt <= '0;
          if (en) begin
            state       <= RUN;
            period_act  <= shadow;
            vr_out      <= 1'b1;
            tooth_pulse <= 1'b1;
            rev_pulse   <= 1'b1;
          end else begin
            vr_out      <= 1'b0;
            tooth_pulse <= 1'b0;
            rev_pulse   <= 1'b0;
          end
        end
        RUN: begin
          if (!en) begin
            state       <= IDLE;
            phase       <= '0;
            tooth_cnt   <= '0;
            vr_out      <= 1'b0;
            tooth_pulse <= 1'b0;
            rev_pulse   <= 1'b0;
          end else if (at_end) begin
            phase       <= '0;
            tooth_cnt   <= next_tooth;
            period_act  <= shadow;
            vr_out      <= next_real;
            tooth_pulse <= next_real;
            rev_pulse   <= (next_tooth == '0);
          end else begin
            phase       <= phase_inc;
            vr_out      <= cur_real && (phase_inc < half);
            tooth_pulse <= 1'b0;
            rev_pulse   <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          phase       <= '0;
          tooth_cnt   <= '0;
          vr_out      <= 1'b0;
          tooth_pulse <= 1'b0;
          rev_pulse   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vr_wheel_gen.sv
// tb/tb_vr_wheel_gen.sv - directed self-checking bench for vr_wheel_gen on a 6-2 wheel
module tb_vr_wheel_gen;

  localparam int TN = 6;
  localparam int MN = 2;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [PW-1:0] period_in = '0;
  logic          period_we = 1'b0;
  logic          vr_out;
  logic [2:0]    tooth_cnt;
  logic          tooth_pulse;
  logic          rev_pulse;
  logic [PW-1:0] period_act;

  int passed = 0;
  int total  = 0;

  vr_wheel_gen #(
    .TOOTH_NUM (TN),
    .MISS_NUM  (MN),
    .PERIOD_W  (PW),
    .PERIOD_RST(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .period_in  (period_in),
    .period_we  (period_we),
    .vr_out     (vr_out),
    .tooth_cnt  (tooth_cnt),
    .tooth_pulse(tooth_pulse),
    .rev_pulse  (rev_pulse),
    .period_act (period_act)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input int vr, input int tc, input int tp,
                         input int rp, input int pa);
    chk({tag, "_vr"}, 32'(vr_out), vr);
    chk({tag, "_tooth"}, 32'(tooth_cnt), tc);
    chk({tag, "_tpulse"}, 32'(tooth_pulse), tp);
    chk({tag, "_rpulse"}, 32'(rev_pulse), rp);
    chk({tag, "_pact"}, 32'(period_act), pa);
  endtask

  // Starting at phase 0 of first_tooth, check n whole teeth of period p, one cycle at a time.
  task automatic run_teeth(input string tag, input int p, input int first_tooth, input int n);
    for (int t = 0; t < n; t++) begin
      int tooth;
      bit real_t;
      tooth  = (first_tooth + t) % TN;
      real_t = (tooth < TN - MN);
      for (int ph = 0; ph < p; ph++) begin
        chk_all($sformatf("%s_t%0d_p%0d", tag, tooth, ph),
                int'(real_t && (ph < p / 2)), tooth, int'(real_t && ph == 0),
                int'(tooth == 0 && ph == 0), p);
        step();
      end
    end
  endtask

  task automatic write_period(input int p);
    period_in = PW'(p);
    period_we = 1'b1;
    step();
    period_we = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    rst = 1'b0;
    chk_all("reset", 0, 0, 0, 0, 4);

    // Basic 6-2 pattern, two full revolutions: 1100 x4 then 0000 x2
    en = 1'b1;
    step();
    run_teeth("basic", 4, 0, 12);

    // Stop mid-tooth at phase 1 of tooth 1, then restart
    run_teeth("pre_stop", 4, 0, 1);
    step();
    chk_all("t1p1", 1, 1, 0, 0, 4);
    en = 1'b0;
    step();
    chk_all("stop", 0, 0, 0, 0, 4);
    step();
    chk_all("idle_hold", 0, 0, 0, 0, 4);
    en = 1'b1;
    step();
    chk_all("restart", 1, 0, 1, 1, 4);

    // Reset mid-tooth after a pending shadow write; shadow must also return to 4
    step();
    write_period(9);
    rst = 1'b1;
    en  = 1'b0;
    step();
    chk_all("rst_mid", 0, 0, 0, 0, 4);
    rst = 1'b0;
    en  = 1'b1;
    step();
    run_teeth("after_rst", 4, 0, 6);

    // Odd period written in IDLE: 11000 real, 00000 missing
    en = 1'b0;
    step();
    write_period(5);
    en = 1'b1;
    step();
    run_teeth("odd", 5, 0, 6);

    // Mid-tooth update: write 8 at phase 1 of tooth 2
    en = 1'b0;
    step();
    write_period(4);
    en = 1'b1;
    step();
    run_teeth("mid", 4, 0, 2);
    chk_all("mid_t2p0", 1, 2, 1, 0, 4);
    step();
    chk_all("mid_t2p1", 1, 2, 0, 0, 4);
    write_period(8);
    chk_all("mid_t2p2", 0, 2, 0, 0, 4);
    step();
    chk_all("mid_t2p3", 0, 2, 0, 0, 4);
    step();
    run_teeth("mid_new", 8, 3, 4);

    // Write during the last phase of tooth 1: tooth 2 keeps 8, tooth 3 onward uses 6
    for (int i = 0; i < 7; i++) step();
    chk_all("late_t1p7", 0, 1, 0, 0, 8);
    write_period(6);
    run_teeth("late_n1", 8, 2, 1);
    run_teeth("late_n2", 6, 3, 4);

    // Clamp: write 0 then 1, both store 2; real teeth become 10
    step();
    period_in = '0;
    period_we = 1'b1;
    step();
    period_in = PW'(1);
    step();
    period_we = 1'b0;
    chk_all("clamp_t1p3", 0, 1, 0, 0, 6);
    step();
    step();
    step();
    run_teeth("clamp", 2, 2, 6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
